// File: rtl/avalon_pio_edge_pkg.sv
// Shared constants for the edge-capturing Avalon-MM PIO.
package avalon_pio_edge_pkg;

  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_DATA    = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_OUT     = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE    = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLR  = 3'd5;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

endpackage

// File: rtl/pio_edge_detect.sv
// Input synchroniser, previous-sample flop and per-bit edge detector.
module pio_edge_detect
  import avalon_pio_edge_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned EDGE_TYPE   = EDGE_RISING,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_sync_q,
  output logic [WIDTH-1:0] o_edge_pulse
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;

  // Shift the asynchronous input through the synchroniser, then keep one older sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_prev <= '0;
    end else begin
      r_sync[0] <= i_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync_q = r_sync[SYNC_STAGES-1];

  // Select the edge polarity that produces a capture pulse.
  always_comb begin
    o_edge_pulse = '0;
    case (EDGE_TYPE)
      EDGE_FALLING: o_edge_pulse = ~o_sync_q & r_prev;
      EDGE_ANY:     o_edge_pulse = o_sync_q ^ r_prev;
      default:      o_edge_pulse = o_sync_q & ~r_prev;
    endcase
  end

endmodule

// File: rtl/avalon_pio_edge.sv
// Avalon-MM PIO slave: output register with atomic set/clear, synchronised
// inputs with sticky edge capture, and a maskable level interrupt.
module avalon_pio_edge
  import avalon_pio_edge_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = '0,
  parameter int unsigned EDGE_TYPE   = EDGE_RISING,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [WIDTH-1:0]  out_port,
  output logic              irq
);

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;
  logic             r_irq;

  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_sync_q;
  logic [WIDTH-1:0] w_edge_pulse;
  logic [WIDTH-1:0] w_out_next;
  logic [WIDTH-1:0] w_mask_next;
  logic [WIDTH-1:0] w_edge_next;
  logic [31:0]      w_readdata;

  assign w_wr = chipselect & ~write_n;
  assign w_wd = writedata[WIDTH-1:0];

  pio_edge_detect #(
    .WIDTH       (WIDTH),
    .EDGE_TYPE   (EDGE_TYPE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_detect (
    .clk          (clk),
    .rst_n        (reset_n),
    .i_in         (in_port),
    .o_sync_q     (w_sync_q),
    .o_edge_pulse (w_edge_pulse)
  );

  // Next-state of the software-visible registers; a new edge wins over a clear on the same bit.
  always_comb begin
    w_out_next  = r_out;
    w_mask_next = r_mask;
    w_edge_next = r_edge;
    if (w_wr) begin
      case (address)
        ADDR_OUT:     w_out_next  = w_wd;
        ADDR_OUTSET:  w_out_next  = r_out | w_wd;
        ADDR_OUTCLR:  w_out_next  = r_out & ~w_wd;
        ADDR_IRQMASK: w_mask_next = w_wd;
        ADDR_EDGE:    w_edge_next = r_edge & ~w_wd;
        default:      ;
      endcase
    end
    w_edge_next = w_edge_next | w_edge_pulse;
  end

  // Register update; irq looks at next-state so it tracks capture, mask and clear on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out  <= RESET_VALUE[WIDTH-1:0];
      r_mask <= '0;
      r_edge <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_out  <= w_out_next;
      r_mask <= w_mask_next;
      r_edge <= w_edge_next;
      r_irq  <= |(w_edge_next & w_mask_next);
    end
  end

  // Zero-wait-state read mux, zero-extended above WIDTH.
  always_comb begin
    w_readdata = '0;
    case (address)
      ADDR_DATA:    w_readdata[WIDTH-1:0] = w_sync_q;
      ADDR_OUT:     w_readdata[WIDTH-1:0] = r_out;
      ADDR_IRQMASK: w_readdata[WIDTH-1:0] = r_mask;
      ADDR_EDGE:    w_readdata[WIDTH-1:0] = r_edge;
      default:      ;
    endcase
  end

  assign readdata = w_readdata;
  assign out_port = r_out;
  assign irq      = r_irq;

endmodule
